// File: rtl/connect_speed_detect_pkg.sv
// Shared USB host-controller constants: bus line levels, reported connect
// states and the connect/disconnect detector state encodings.
package connect_speed_detect_pkg;

    typedef enum logic [1:0] {
        LINE_SE0  = 2'b00,
        LINE_LS_J = 2'b01,
        LINE_FS_J = 2'b10,
        LINE_SE1  = 2'b11
    } line_state_t;

    typedef enum logic [1:0] {
        CONN_NONE = 2'b00,
        CONN_LOW  = 2'b01,
        CONN_FULL = 2'b10
    } connect_state_t;

    typedef enum logic [2:0] {
        ST_DISC      = 3'd0,
        ST_CONN_WAIT = 3'd1,
        ST_CONN_LS   = 3'd2,
        ST_CONN_FS   = 3'd3,
        ST_DISC_WAIT = 3'd4
    } detect_state_t;

    localparam int COUNT_W = 16;

    // Saturating increment so very long stable levels never wrap back to zero.
    function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] value);
        return (value == '1) ? value : value + 1'b1;
    endfunction

endpackage

// File: rtl/connect_speed_detect.sv
// Debounced USB device attach/detach detector: qualifies a stable J level as a
// low- or full-speed connect and a sustained SE0 as a disconnect.
module connect_speed_detect
    import connect_speed_detect_pkg::*;
#(
    parameter int CONNECT_CYCLES    = 4800,
    parameter int DISCONNECT_CYCLES = 120
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] lineState,
    input  logic       detectEnable,
    input  logic       txActive,
    output logic [1:0] connectState,
    output logic       fullSpeedRate,
    output logic       fullSpeedPol,
    output logic       connectEvent,
    output logic       disconnectEvent
);

    localparam logic [COUNT_W-1:0] CONN_LAST = COUNT_W'(CONNECT_CYCLES - 1);
    localparam logic [COUNT_W-1:0] DISC_LAST = COUNT_W'(DISCONNECT_CYCLES - 1);

    detect_state_t      state, state_n;
    logic [COUNT_W-1:0] cnt, cnt_n, cnt_inc;
    logic [1:0]         cand, cand_n;
    logic [1:0]         conn_state_n;
    logic               conn_evt_n, disc_evt_n;

    assign cnt_inc = sat_inc(cnt);

    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        cand_n     = cand;
        conn_evt_n = 1'b0;
        disc_evt_n = 1'b0;

        if (!detectEnable) begin
            state_n    = ST_DISC;
            cnt_n      = '0;
            cand_n     = LINE_SE0;
            disc_evt_n = (state == ST_CONN_LS) || (state == ST_CONN_FS) ||
                         (state == ST_DISC_WAIT);
        end else if (!txActive) begin
            case (state)
                ST_DISC: begin
                    if (lineState == LINE_FS_J || lineState == LINE_LS_J) begin
                        cand_n  = lineState;
                        cnt_n   = '0;
                        state_n = ST_CONN_WAIT;
                    end
                end
                ST_CONN_WAIT: begin
                    if (lineState == cand) begin
                        cnt_n = cnt_inc;
                        if (cnt_inc >= CONN_LAST) begin
                            state_n    = (cand == LINE_FS_J) ? ST_CONN_FS : ST_CONN_LS;
                            conn_evt_n = 1'b1;
                        end
                    end else begin
                        state_n = ST_DISC;
                        cnt_n   = '0;
                    end
                end
                ST_CONN_LS, ST_CONN_FS: begin
                    if (lineState == LINE_SE0) begin
                        cnt_n   = '0;
                        state_n = ST_DISC_WAIT;
                    end
                end
                ST_DISC_WAIT: begin
                    // Short SE0 runs (EOP, keep-alive) fall back to the speed kept in cand.
                    if (lineState == LINE_SE0) begin
                        cnt_n = cnt_inc;
                        if (cnt_inc >= DISC_LAST) begin
                            state_n    = ST_DISC;
                            disc_evt_n = 1'b1;
                        end
                    end else begin
                        state_n = (cand == LINE_FS_J) ? ST_CONN_FS : ST_CONN_LS;
                    end
                end
                default: begin
                    state_n = ST_DISC;
                    cnt_n   = '0;
                    cand_n  = LINE_SE0;
                end
            endcase
        end
    end

    always_comb begin
        conn_state_n = CONN_NONE;
        case (state_n)
            ST_CONN_LS:   conn_state_n = CONN_LOW;
            ST_CONN_FS:   conn_state_n = CONN_FULL;
            ST_DISC_WAIT: conn_state_n = (cand_n == LINE_FS_J) ? CONN_FULL : CONN_LOW;
            default:      conn_state_n = CONN_NONE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state           <= ST_DISC;
            cnt             <= '0;
            cand            <= LINE_SE0;
            connectState    <= CONN_NONE;
            fullSpeedRate   <= 1'b0;
            fullSpeedPol    <= 1'b0;
            connectEvent    <= 1'b0;
            disconnectEvent <= 1'b0;
        end else begin
            state           <= state_n;
            cnt             <= cnt_n;
            cand            <= cand_n;
            connectState    <= conn_state_n;
            fullSpeedRate   <= (conn_state_n == CONN_FULL);
            fullSpeedPol    <= (conn_state_n == CONN_FULL);
            connectEvent    <= conn_evt_n;
            disconnectEvent <= disc_evt_n;
        end
    end

endmodule
